// File: rtl/btn_symbol_encoder_if.sv
// Button/symbol bundle for btn_symbol_encoder: raw buttons in, symbol stream and debounced levels out.
// master = button source / symbol consumer, slave = the encoder.
interface btn_symbol_encoder_if;
    logic [1:0] btn;
    logic [1:0] sym;
    logic       sym_valid;
    logic [1:0] stable;

    modport master (
        output btn,
        input  sym,
        input  sym_valid,
        input  stable
    );

    modport slave (
        input  btn,
        output sym,
        output sym_valid,
        output stable
    );
endinterface

// File: rtl/btn_symbol_encoder.sv
// Two-button input stage: per-bit synchronizer, counter debounce and rise detect, then a combine FSM
// producing one-cycle symbols. Define SYMBOL_HOLD_EN to hold sym from EMIT until both buttons release.
module btn_symbol_encoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned COMBINE_WINDOW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    btn_symbol_encoder_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned WIN_W = (COMBINE_WINDOW > 1) ? $clog2(COMBINE_WINDOW) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIN_W-1:0] WIN_INIT = WIN_W'(COMBINE_WINDOW - 1);

`ifdef SYMBOL_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_EMIT    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    logic [1:0]       sync1_q;
    logic [1:0]       sync2_q;
    logic [1:0]       stable_q;
    logic [1:0]       rise_q;
    logic [CNT_W-1:0] cnt_q [2];
    logic [1:0]       upd_c;

    state_t           state_q;
    state_t           state_n;
    logic [1:0]       mask_q;
    logic [1:0]       mask_n;
    logic [WIN_W-1:0] wcnt_q;
    logic [WIN_W-1:0] wcnt_n;
    logic [1:0]       sym_q;
    logic [1:0]       sym_n;
    logic             sym_valid_q;
    logic             sym_valid_n;
    logic [1:0]       merged_c;

    // A bit's debounced level flips on the last of DEBOUNCE_CYCLES consecutive mismatching edges
    always_comb begin
        upd_c = 2'b00;
        for (int b = 0; b < 2; b++) begin
            upd_c[b] = (sync2_q[b] != stable_q[b]) && (cnt_q[b] == CNT_LAST);
        end
    end

    // Synchronizer, debounce counters, debounced level and registered rise strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 2'b00;
            sync2_q  <= 2'b00;
            stable_q <= 2'b00;
            rise_q   <= 2'b00;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
        end else begin
            sync1_q <= bus.btn;
            sync2_q <= sync1_q;
            rise_q  <= upd_c & sync2_q;
            for (int b = 0; b < 2; b++) begin
                if (sync2_q[b] == stable_q[b]) begin
                    cnt_q[b] <= '0;
                end else if (upd_c[b]) begin
                    cnt_q[b]    <= '0;
                    stable_q[b] <= sync2_q[b];
                end else begin
                    cnt_q[b] <= cnt_q[b] + CNT_W'(1);
                end
            end
        end
    end

    // Combine FSM state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mask_q      <= 2'b00;
            wcnt_q      <= '0;
            sym_q       <= 2'b00;
            sym_valid_q <= 1'b0;
        end else begin
            state_q     <= state_n;
            mask_q      <= mask_n;
            wcnt_q      <= wcnt_n;
            sym_q       <= sym_n;
            sym_valid_q <= sym_valid_n;
        end
    end

    assign merged_c = mask_q | rise_q;

    // Next state; sym/sym_valid are decoded for the state being entered so they appear registered
    always_comb begin
        state_n     = state_q;
        mask_n      = mask_q;
        wcnt_n      = wcnt_q;
        sym_n       = 2'b00;
        sym_valid_n = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rise_q == 2'b11) begin
                    state_n     = S_EMIT;
                    mask_n      = 2'b11;
                    sym_n       = 2'b11;
                    sym_valid_n = 1'b1;
                end else if (rise_q != 2'b00) begin
                    state_n = S_WAIT;
                    mask_n  = rise_q;
                    wcnt_n  = WIN_INIT;
                end
            end
            S_WAIT: begin
                mask_n = merged_c;
                if ((merged_c == 2'b11) || (wcnt_q == '0)) begin
                    state_n     = S_EMIT;
                    sym_n       = merged_c;
                    sym_valid_n = 1'b1;
                end else begin
                    wcnt_n = wcnt_q - WIN_W'(1);
                end
            end
            S_EMIT: begin
                state_n = S_RELEASE;
                if (HOLD_EN) begin
                    sym_n = mask_q;
                end
            end
            S_RELEASE: begin
                // Rises here are dropped: a new episode starts only after both buttons are released
                if (stable_q == 2'b00) begin
                    state_n = S_IDLE;
                end else if (HOLD_EN) begin
                    sym_n = mask_q;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign bus.sym       = sym_q;
    assign bus.sym_valid = sym_valid_q;
    assign bus.stable    = stable_q;

endmodule

// File: tb/tb_btn_symbol_encoder.sv
// Self-checking bench for btn_symbol_encoder: directed scenarios plus randomized bouncy buttons,
// every cycle compared against an event-level reference model.
module tb_btn_symbol_encoder;

    localparam int D = 4;
    localparam int W = 2;
`ifdef SYMBOL_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    btn_symbol_encoder_if bus();

    btn_symbol_encoder #(
        .DEBOUNCE_CYCLES(D),
        .COMBINE_WINDOW (W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Reference model: debounce as "last D synchronized samples all disagree with the level",
    // combine as episodes (first rise opens a W-edge window, emit locks until both levels are 0).
    logic [1:0] m_s1, m_s2, m_stab, m_rise, m_mask;
    logic [1:0] m_hist[$];
    int         m_mode;      // 0 idle, 1 collecting, 2 locked after emit
    int         m_now = 0;
    int         m_deadline, m_emit_edge;
    logic [1:0] exp_sym;
    logic       exp_valid;

    always @(posedge clk) begin : model
        logic [1:0] ns, nr;
        bit         emit, all_diff;
        m_now++;
        if (rst) begin
            m_s1 = 2'b00; m_s2 = 2'b00; m_stab = 2'b00; m_rise = 2'b00; m_mask = 2'b00;
            m_hist.delete();
            m_mode = 0; exp_sym = 2'b00; exp_valid = 1'b0;
        end else begin
            emit      = 1'b0;
            exp_valid = 1'b0;
            if (m_mode == 2) begin
                if (m_now >= m_emit_edge + 2 && m_stab == 2'b00) m_mode = 0;
            end else if (m_mode == 0) begin
                if (m_rise != 2'b00) begin
                    m_mask = m_rise;
                    if (m_mask == 2'b11) emit = 1'b1;
                    else begin m_mode = 1; m_deadline = m_now + W; end
                end
            end else begin
                m_mask = m_mask | m_rise;
                if (m_mask == 2'b11 || m_now == m_deadline) emit = 1'b1;
            end
            if (emit) begin m_mode = 2; m_emit_edge = m_now; exp_valid = 1'b1; end
            exp_sym = (emit || (HOLD && m_mode == 2)) ? m_mask : 2'b00;

            m_hist.push_back(m_s2);
            if (m_hist.size() > D) void'(m_hist.pop_front());
            ns = m_stab;
            nr = 2'b00;
            for (int b = 0; b < 2; b++) begin
                all_diff = (m_hist.size() == D);
                foreach (m_hist[i]) if (m_hist[i][b] == m_stab[b]) all_diff = 1'b0;
                if (all_diff) begin ns[b] = ~m_stab[b]; nr[b] = ~m_stab[b]; end
            end
            m_stab = ns; m_rise = nr; m_s2 = m_s1; m_s1 = bus.btn;
        end
    end

    // Drive buttons at the falling edge, then advance to the next falling edge (edge index = call index)
    task automatic tick(input logic [1:0] b);
        bus.btn = b;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.btn = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.btn = 2'b11;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.sym, bus.sym_valid, bus.stable} !== 5'b0) begin
            errors++;
            $display("FAIL reset_state got sym=%b v=%b st=%b exp all zero", bus.sym, bus.sym_valid, bus.stable);
        end
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick(2'b00);
            checks++;
            if ({bus.sym, bus.sym_valid, bus.stable} !== 5'b0) begin
                errors++;
                $display("FAIL idle k=%0d got sym=%b v=%b st=%b exp all zero", k, bus.sym, bus.sym_valid, bus.stable);
            end
        end
    endtask

    task automatic test_single();
        int n = 0, vt = -1;
        logic [1:0] vs = 2'b00;
        do_reset();
        for (int k = 0; k < 40; k++) begin
            tick(k < 20 ? 2'b01 : 2'b00);
            checks++;
            if ({bus.sym, bus.sym_valid, bus.stable} !== {exp_sym, exp_valid, m_stab}) begin
                errors++;
                $display("FAIL single_model k=%0d got %b/%b/%b exp %b/%b/%b", k, bus.sym, bus.sym_valid, bus.stable, exp_sym, exp_valid, m_stab);
            end
            if (bus.sym_valid) begin n++; vt = k; vs = bus.sym; end
            if (k == 4 || k == 5 || k == 24 || k == 25) begin
                checks++;
                if (bus.stable !== ((k == 5 || k == 24) ? 2'b01 : 2'b00)) begin
                    errors++;
                    $display("FAIL single_stable k=%0d got %b", k, bus.stable);
                end
            end
        end
        checks++;
        if (n != 1 || vt != 8 || vs !== 2'b01) begin
            errors++;
            $display("FAIL single_emit got n=%0d at=%0d sym=%b exp n=1 at=8 sym=01", n, vt, vs);
        end
    endtask

    task automatic test_bounce();
        logic pat [0:8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        int n = 0, vt = -1, fs = -1;
        logic [1:0] vs = 2'b00;
        logic b1;
        do_reset();
        for (int k = 0; k < 50; k++) begin
            b1 = (k < 9) ? pat[k] : (k < 34);
            tick({b1, 1'b0});
            checks++;
            if ({bus.sym, bus.sym_valid, bus.stable} !== {exp_sym, exp_valid, m_stab}) begin
                errors++;
                $display("FAIL bounce_model k=%0d got %b/%b/%b exp %b/%b/%b", k, bus.sym, bus.sym_valid, bus.stable, exp_sym, exp_valid, m_stab);
            end
            if (fs < 0 && bus.stable[1]) fs = k;
            if (bus.sym_valid) begin n++; vt = k; vs = bus.sym; end
        end
        checks++;
        if (fs != 14 || n != 1 || vt != 17 || vs !== 2'b10) begin
            errors++;
            $display("FAIL bounce_emit got stable_at=%0d n=%0d at=%0d sym=%b exp 14 1 17 10", fs, n, vt, vs);
        end
    endtask

    task automatic test_combine();
        int n, vt, t2;
        logic [1:0] vs, v2, b;
        for (int sc = 0; sc < 3; sc++) begin
            do_reset();
            n = 0; vt = -1; t2 = -1; vs = 2'b00; v2 = 2'b00;
            for (int k = 0; k < 76; k++) begin
                case (sc)
                    0:       b = (k < 15) ? 2'b11 : 2'b00;
                    1:       b = (k < 20) ? {k >= 1, 1'b1} : 2'b00;
                    default: b = (k < 25) ? {k >= 6, 1'b1} : ((k >= 40 && k < 60) ? 2'b10 : 2'b00);
                endcase
                tick(b);
                checks++;
                if ({bus.sym, bus.sym_valid, bus.stable} !== {exp_sym, exp_valid, m_stab}) begin
                    errors++;
                    $display("FAIL combine%0d_model k=%0d got %b/%b/%b exp %b/%b/%b", sc, k, bus.sym, bus.sym_valid, bus.stable, exp_sym, exp_valid, m_stab);
                end
                if (bus.sym_valid) begin
                    n++;
                    if (n == 1) begin vt = k; vs = bus.sym; end else begin t2 = k; v2 = bus.sym; end
                end
            end
            checks++;
            if (sc == 0 && (n != 1 || vt != 6 || vs !== 2'b11)) begin
                errors++;
                $display("FAIL combine_same got n=%0d at=%0d sym=%b exp 1 6 11", n, vt, vs);
            end else if (sc == 1 && (n != 1 || vt != 7 || vs !== 2'b11)) begin
                errors++;
                $display("FAIL combine_window got n=%0d at=%0d sym=%b exp 1 7 11", n, vt, vs);
            end else if (sc == 2 && (n != 2 || vt != 8 || vs !== 2'b01 || t2 != 48 || v2 !== 2'b10)) begin
                errors++;
                $display("FAIL combine_late got n=%0d %0d:%b %0d:%b exp 2 8:01 48:10", n, vt, vs, t2, v2);
            end
        end
    endtask

    task automatic test_reset_in_wait();
        int n = 0, vt = -1;
        logic [1:0] vs = 2'b00;
        do_reset();
        for (int k = 0; k < 46; k++) begin
            rst = (k == 7);
            tick(k < 35 ? 2'b01 : 2'b00);
            checks++;
            if ({bus.sym, bus.sym_valid, bus.stable} !== {exp_sym, exp_valid, m_stab}) begin
                errors++;
                $display("FAIL rstwait_model k=%0d got %b/%b/%b exp %b/%b/%b", k, bus.sym, bus.sym_valid, bus.stable, exp_sym, exp_valid, m_stab);
            end
            if (bus.sym_valid) begin n++; vt = k; vs = bus.sym; end
        end
        rst = 1'b0;
        // Reset at edge 7 restarts the chain: edge 8 plays the role of edge 0 of a fresh press
        checks++;
        if (n != 1 || vt != 16 || vs !== 2'b01) begin
            errors++;
            $display("FAIL rstwait_emit got n=%0d at=%0d sym=%b exp 1 16 01", n, vt, vs);
        end
    endtask

    task automatic test_hold();
        int nv = 0, ns = 0;
        do_reset();
        for (int k = 0; k < 50; k++) begin
            tick(k < 30 ? 2'b01 : 2'b00);
            checks++;
            if ({bus.sym, bus.sym_valid, bus.stable} !== {exp_sym, exp_valid, m_stab}) begin
                errors++;
                $display("FAIL hold_model k=%0d got %b/%b/%b exp %b/%b/%b", k, bus.sym, bus.sym_valid, bus.stable, exp_sym, exp_valid, m_stab);
            end
            if (bus.sym_valid) nv++;
            if (bus.sym == 2'b01) ns++;
        end
        checks++;
        if (nv != 1 || ns != (HOLD ? 28 : 1)) begin
            errors++;
            $display("FAIL hold_len got valid=%0d sym01_cycles=%0d exp 1 %0d", nv, ns, HOLD ? 28 : 1);
        end
    endtask

    task automatic test_random();
        int rem[2] = '{0, 0};
        logic [1:0] lvl = 2'b00, b;
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (rem[i] == 0) begin
                    lvl[i] = 1'($urandom_range(0, 1));
                    rem[i] = int'($urandom_range(1, 24));
                end
                rem[i]--;
                b[i] = lvl[i] ^ ($urandom_range(0, 9) == 0);
            end
            rst = ($urandom_range(0, 499) == 0);
            tick(b);
            checks++;
            if ({bus.sym, bus.sym_valid, bus.stable} !== {exp_sym, exp_valid, m_stab}) begin
                errors++;
                $display("FAIL random_model k=%0d got %b/%b/%b exp %b/%b/%b", k, bus.sym, bus.sym_valid, bus.stable, exp_sym, exp_valid, m_stab);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        bus.btn = 2'b00;
        test_reset();
        test_single();
        test_bounce();
        test_combine();
        test_reset_in_wait();
        test_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/btn_symbol_encoder.md
Name: btn_symbol_encoder

Overview:
- Input stage that drives the 2-bit symbol input of the two-state-bit sequence FSM.
- Converts two raw, bouncy, asynchronous push-buttons into clean one-cycle symbols: 00 idle, 01 button 0, 10 button 1, 11 both.
- Per-bit chain: 2-FF synchronizer, counter debounce, rise detect. A combine FSM then merges near-simultaneous presses into one symbol and blocks repeats until both buttons are released.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive clk edges a synchronized level must differ from the debounced level before the debounced level updates (>=1)
COMBINE_WINDOW, 2, cycles spent in WAIT collecting a second press before emitting (>=1)

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  reset, synchronous, active-high
btn  input  2  raw asynchronous buttons, active-high; bit0 = button 0
sym  output 2  symbol to the FSM input; 00 except during emit
sym_valid  output 1  high exactly one cycle per emitted symbol
stable  output 2  debounced button levels

Behaviour:
- Reset (rst high at posedge): sync regs, stable, debounce counters, rise, mask = 0; FSM = IDLE; sym = 00; sym_valid = 0. Reset overrides all activity, including mid-WAIT or mid-EMIT; no symbol is emitted afterwards for a press captured before reset.
- Synchronizer: sync1 <= btn; sync2 <= sync1, per bit.
- Debounce, per bit, with counter width clog2(DEBOUNCE_CYCLES+1):
  - sync2 == stable: counter <= 0.
  - Otherwise counter increments. On the DEBOUNCE_CYCLES-th consecutive mismatching edge, stable <= sync2 and counter <= 0.
  - Any glitch shorter than that restarts the count.
  - Release is debounced identically.
- rise[b] is registered: rise[b] <= (stable[b] updates 0->1 this edge). It is high for one cycle.
- Timeline for btn rising before edge e0: stable = 1 after edge e(1+D); rise = 1 after e(1+D).
- FSM states: IDLE, WAIT, EMIT, RELEASE.
  - IDLE:
    - rise == 11 -> EMIT, mask = 11.
    - rise == 01 or 10 -> WAIT, mask = rise, wcnt = COMBINE_WINDOW-1.
    - Otherwise stay.
  - WAIT:
    - mask <= mask | rise.
    - If (mask | rise) == 11 or wcnt == 0 -> EMIT.
    - Otherwise wcnt decrements.
  - EMIT: sym = mask, sym_valid = 1 for exactly this cycle (registered outputs); next state RELEASE.
  - RELEASE: sym = 00. Go to IDLE only when stable == 00. All rises in RELEASE are ignored.
- Latency, single press, defaults (D=4, W=2): WAIT entered at e6; EMIT at e8; sym = 01 during the cycle after e8, so the downstream FSM samples it at e9.
- Simultaneous press (same rise cycle): EMIT entered at e6, sym = 11.
- Second button rising within the window -> 11. Rising after the window -> ignored until full release.
- sym is never 11 unless both rises fell inside one IDLE/WAIT episode.

Optional Feature:
SYMBOL_HOLD_EN
- Defined: sym holds mask from EMIT through RELEASE until stable == 00 (level output for FSMs that need it held); clears to 00 on the IDLE transition. sym_valid remains a one-cycle pulse.
- Undefined: sym is 00 in every state except EMIT, as above.

Test Plan:
- Reset then idle 20 cycles, btn=00 -> sym=00, sym_valid=0, stable=00 throughout.
- btn[0] 0->1 clean before e0, held 20 cycles, then released -> stable[0]=1 after e5; sym=01 with sym_valid=1 for exactly one cycle after e8; no further symbols; FSM returns to IDLE 5 edges after the release reaches sync2.
- btn[1] bounce: pulses of 1,2,3 cycles high separated by 1 low, then held high -> stable[1] rises only after 4 consecutive high samples; exactly one sym=10.
- btn=11 same cycle -> single sym=11 after e6. Separately, btn[0] at e0 and btn[1] at e1 -> single sym=11. Separately, btn[1] at e0+6 cycles -> sym=01 only, btn[1] ignored until both released.
- rst pulsed one cycle while in WAIT (btn[0] held) -> no symbol emitted. btn[0] still held after reset -> re-debounced and emits 01 DEBOUNCE_CYCLES+2+W edges after rst deassert.
- With SYMBOL_HOLD_EN: press btn[0] for 30 cycles -> sym=01 from EMIT until stable==00; sym_valid high exactly one cycle.
